// File: rtl/id_pkg.sv
// Shared encodings for the decode stage: MIPS32 opcode/func values, control-field
// encodings, stage FSM states and the registered control bundle layout.
package id_pkg;

  localparam int unsigned FIELD_W = 5;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_ADDU = 4'b0111;
  localparam logic [3:0] ALU_SUBU = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] AF_SIGN = 2'b00;
  localparam logic [1:0] AF_ZERO = 2'b01;
  localparam logic [1:0] AF_UPPR = 2'b10;

  localparam logic [2:0] BF_NONE = 3'b000;
  localparam logic [2:0] BF_BLTZ = 3'b010;
  localparam logic [2:0] BF_BGEZ = 3'b011;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_REG = 2'b01;
  localparam logic [1:0] PC_BR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] GP_ALU   = 2'b00;
  localparam logic [1:0] GP_MEM   = 2'b01;
  localparam logic [1:0] GP_SHIFT = 2'b10;
  localparam logic [1:0] GP_LINK  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_FULL   = 2'b01,
    ST_BUBBLE = 2'b10
  } state_t;

  typedef struct packed {
    logic [1:0] pc_mux_sel;
    logic [1:0] gp_mux_sel;
    logic       alu_src;
    logic       gp_we;
    logic       mem_we;
    logic       mem_to_reg;
    logic [3:0] alu_op;
    logic [1:0] af;
    logic [2:0] bf;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational MIPS32 subset decoder: control bundle, destination register,
// source-usage flags for the interlock, and illegal-instruction detection.
module id_decode_comb
  import id_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned FLAG_ILL = 1
) (
  input  logic [5:0]         i_op,
  input  logic [5:0]         i_func,
  input  logic [FIELD_W-1:0] i_rt,
  input  logic [FIELD_W-1:0] i_rd,
  output ctrl_t              o_ctrl_c,
  output logic [REG_AW-1:0]  o_cad_c,
  output logic               o_uses_rs_c,
  output logic               o_uses_rt_c
);

  logic w_ill;

  always_comb begin
    o_ctrl_c    = '0;
    o_cad_c     = '0;
    o_uses_rs_c = 1'b1;
    o_uses_rt_c = 1'b0;
    w_ill       = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl_c.gp_we = 1'b1;
        o_cad_c        = REG_AW'(i_rd);
        o_uses_rt_c    = 1'b1;
        case (i_func)
          FN_SLL, FN_SRL, FN_SRA: begin
            o_ctrl_c.gp_mux_sel = GP_SHIFT;
            o_uses_rs_c         = 1'b0;
          end
          FN_SLLV, FN_SRLV, FN_SRAV: o_ctrl_c.gp_mux_sel = GP_SHIFT;
          FN_ADD:  o_ctrl_c.alu_op = ALU_ADD;
          FN_ADDU: o_ctrl_c.alu_op = ALU_ADDU;
          FN_SUB:  o_ctrl_c.alu_op = ALU_SUB;
          FN_SUBU: o_ctrl_c.alu_op = ALU_SUBU;
          FN_AND:  o_ctrl_c.alu_op = ALU_AND;
          FN_OR:   o_ctrl_c.alu_op = ALU_OR;
          FN_XOR:  o_ctrl_c.alu_op = ALU_XOR;
          FN_NOR:  o_ctrl_c.alu_op = ALU_NOR;
          FN_SLT:  o_ctrl_c.alu_op = ALU_SLT;
          FN_SLTU: o_ctrl_c.alu_op = ALU_SLTU;
          FN_JR: begin
            o_ctrl_c.pc_mux_sel = PC_REG;
            o_ctrl_c.gp_we      = 1'b0;
          end
          FN_JALR: begin
            o_ctrl_c.pc_mux_sel = PC_REG;
            o_ctrl_c.gp_mux_sel = GP_LINK;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OP_LW: begin
        o_ctrl_c.alu_src    = 1'b1;
        o_ctrl_c.gp_we      = 1'b1;
        o_ctrl_c.mem_to_reg = 1'b1;
        o_ctrl_c.gp_mux_sel = GP_MEM;
        o_cad_c             = REG_AW'(i_rt);
      end
      OP_SW: begin
        o_ctrl_c.alu_src = 1'b1;
        o_ctrl_c.mem_we  = 1'b1;
        o_uses_rt_c      = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        o_ctrl_c.alu_src = 1'b1;
        o_ctrl_c.gp_we   = 1'b1;
        o_cad_c          = REG_AW'(i_rt);
        case (i_op)
          OP_ADDI:  begin o_ctrl_c.alu_op = ALU_ADD;  o_ctrl_c.af = AF_SIGN; end
          OP_ADDIU: begin o_ctrl_c.alu_op = ALU_ADDU; o_ctrl_c.af = AF_SIGN; end
          OP_ANDI:  begin o_ctrl_c.alu_op = ALU_AND;  o_ctrl_c.af = AF_ZERO; end
          OP_ORI:   begin o_ctrl_c.alu_op = ALU_OR;   o_ctrl_c.af = AF_ZERO; end
          OP_XORI:  begin o_ctrl_c.alu_op = ALU_XOR;  o_ctrl_c.af = AF_ZERO; end
          default: begin
            o_ctrl_c.alu_op = ALU_OR;
            o_ctrl_c.af     = AF_UPPR;
            o_uses_rs_c     = 1'b0;
          end
        endcase
      end
      OP_REGIMM: begin
        o_ctrl_c.pc_mux_sel = PC_BR;
        o_ctrl_c.bf         = (i_rt == '0) ? BF_BLTZ : BF_BGEZ;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        o_ctrl_c.pc_mux_sel = PC_BR;
        o_ctrl_c.bf         = {1'b1, i_op[1:0]};
        o_uses_rt_c         = (i_op == OP_BEQ) || (i_op == OP_BNE);
      end
      OP_J: begin
        o_ctrl_c.pc_mux_sel = PC_JMP;
        o_uses_rs_c         = 1'b0;
      end
      OP_JAL: begin
        o_ctrl_c.pc_mux_sel = PC_JMP;
        o_ctrl_c.gp_we      = 1'b1;
        o_ctrl_c.gp_mux_sel = GP_LINK;
        o_cad_c             = REG_AW'(5'd31);
        o_uses_rs_c         = 1'b0;
      end
      default: w_ill = 1'b1;
    endcase
    // Unsupported encodings travel down the pipe as harmless, flagged bundles
    if ((FLAG_ILL != 0) && w_ill) begin
      o_ctrl_c.gp_we      = 1'b0;
      o_ctrl_c.mem_we     = 1'b0;
      o_ctrl_c.pc_mux_sel = PC_SEQ;
      o_ctrl_c.illegal    = 1'b1;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered, handshaked ID stage: decode, EMPTY/FULL/BUBBLE flow control,
// load-use interlock and flush.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned HAZARD_EN = 1,
  parameter int unsigned FLAG_ILL  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_sa,
  output logic [15:0]       out_imm,
  output logic [25:0]       out_jidx,
  output logic [1:0]        out_pc_mux_sel,
  output logic [1:0]        out_gp_mux_sel,
  output logic              out_alu_src,
  output logic              out_gp_we,
  output logic              out_mem_we,
  output logic              out_mem_to_reg,
  output logic [3:0]        out_alu_op,
  output logic [1:0]        out_af,
  output logic [2:0]        out_bf,
  output logic [REG_AW-1:0] out_cad,
  output logic              out_illegal
);

  state_t              r_state, w_state_nxt;
  logic                r_valid;
  ctrl_t               r_ctrl, w_ctrl;
  logic [REG_AW-1:0]   r_cad, w_cad;
  logic [DATA_W-1:0]   r_pc;
  logic [REG_AW-1:0]   r_rs, r_rt, r_rd, r_sa;
  logic [15:0]         r_imm;
  logic [25:0]         r_jidx;
  logic [REG_AW-1:0]   w_rs, w_rt;
  logic                w_uses_rs, w_uses_rt;
  logic                w_load_en, w_hazard, w_accept;

  assign w_rs = REG_AW'(in_instr[25:21]);
  assign w_rt = REG_AW'(in_instr[20:16]);

  id_decode_comb #(
    .REG_AW   (REG_AW),
    .FLAG_ILL (FLAG_ILL)
  ) u_decode (
    .i_op        (in_instr[31:26]),
    .i_func      (in_instr[5:0]),
    .i_rt        (in_instr[20:16]),
    .i_rd        (in_instr[15:11]),
    .o_ctrl_c    (w_ctrl),
    .o_cad_c     (w_cad),
    .o_uses_rs_c (w_uses_rs),
    .o_uses_rt_c (w_uses_rt)
  );

  // Load in the output slot whose destination feeds the incoming instruction
  assign w_hazard = (HAZARD_EN != 0) && r_valid && r_ctrl.mem_to_reg && (r_cad != '0) &&
                    in_valid && ((w_uses_rs && (w_rs == r_cad)) ||
                                 (w_uses_rt && (w_rt == r_cad)));
  assign w_load_en = !r_valid || out_ready;
  assign in_ready  = rst_n && w_load_en && !w_hazard && !flush;
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_accept) begin
      w_state_nxt = ST_FULL;
    end else if (w_load_en) begin
      w_state_nxt = w_hazard ? ST_BUBBLE : ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == ST_FULL);
    end
  end

  // Bundle registers only move on an accepted instruction, so a stalled bundle holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_cad  <= '0;
      r_pc   <= '0;
      r_rs   <= '0;
      r_rt   <= '0;
      r_rd   <= '0;
      r_sa   <= '0;
      r_imm  <= '0;
      r_jidx <= '0;
    end else if (w_accept) begin
      r_ctrl <= w_ctrl;
      r_cad  <= w_cad;
      r_pc   <= in_pc;
      r_rs   <= w_rs;
      r_rt   <= w_rt;
      r_rd   <= REG_AW'(in_instr[15:11]);
      r_sa   <= REG_AW'(in_instr[10:6]);
      r_imm  <= in_instr[15:0];
      r_jidx <= in_instr[25:0];
    end
  end

  assign out_valid      = r_valid;
  assign out_pc         = r_pc;
  assign out_rs         = r_rs;
  assign out_rt         = r_rt;
  assign out_rd         = r_rd;
  assign out_sa         = r_sa;
  assign out_imm        = r_imm;
  assign out_jidx       = r_jidx;
  assign out_pc_mux_sel = r_ctrl.pc_mux_sel;
  assign out_gp_mux_sel = r_ctrl.gp_mux_sel;
  assign out_alu_src    = r_ctrl.alu_src;
  assign out_gp_we      = r_ctrl.gp_we;
  assign out_mem_we     = r_ctrl.mem_we;
  assign out_mem_to_reg = r_ctrl.mem_to_reg;
  assign out_alu_op     = r_ctrl.alu_op;
  assign out_af         = r_ctrl.af;
  assign out_bf         = r_ctrl.bf;
  assign out_cad        = r_cad;
  assign out_illegal    = r_ctrl.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed scenarios plus randomized traffic
// checked against a table-level decode model and a one-slot stage model.
module tb_id_stage_pipe;

  logic        clk, rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [4:0]  out_rs, out_rt, out_rd, out_sa, out_cad;
  logic [15:0] out_imm;
  logic [25:0] out_jidx;
  logic [1:0]  out_pc_mux_sel, out_gp_mux_sel, out_af;
  logic        out_alu_src, out_gp_we, out_mem_we, out_mem_to_reg, out_illegal;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_bf;

  id_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_sa(out_sa), .out_imm(out_imm), .out_jidx(out_jidx),
    .out_pc_mux_sel(out_pc_mux_sel), .out_gp_mux_sel(out_gp_mux_sel),
    .out_alu_src(out_alu_src), .out_gp_we(out_gp_we), .out_mem_we(out_mem_we),
    .out_mem_to_reg(out_mem_to_reg), .out_alu_op(out_alu_op), .out_af(out_af),
    .out_bf(out_bf), .out_cad(out_cad), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [1:0]  pcm, gpm;
    logic        alu_src, gp_we, mem_we, m2r;
    logic [3:0]  alu_op;
    logic [1:0]  af;
    logic [2:0]  bf;
    logic [4:0]  cad;
    logic        ill;
  } bundle_t;

  bundle_t exp_q[$];
  int      n_chk  = 0;
  int      n_pass = 0;
  bit      done   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference decode straight from the instruction-set table
  function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    logic [5:0] op, fn;
    bit ill;
    op = ins[31:26];
    fn = ins[5:0];
    ill = 0;
    b = '0;
    b.pc = pc; b.rs = ins[25:21]; b.rt = ins[20:16]; b.rd = ins[15:11];
    b.sa = ins[10:6]; b.imm = ins[15:0]; b.jidx = ins[25:0];
    if (op == 6'h00) begin
      b.gp_we = 1; b.cad = b.rd;
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) b.gpm = 2'b10;
      else if (fn == 6'h08) begin b.pcm = 2'b01; b.gp_we = 0; end
      else if (fn == 6'h09) begin b.pcm = 2'b01; b.gpm = 2'b11; end
      else case (fn)
        6'h20: b.alu_op = 4'd0;  6'h21: b.alu_op = 4'd7;
        6'h22: b.alu_op = 4'd1;  6'h23: b.alu_op = 4'd8;
        6'h24: b.alu_op = 4'd2;  6'h25: b.alu_op = 4'd3;
        6'h26: b.alu_op = 4'd4;  6'h27: b.alu_op = 4'd5;
        6'h2A: b.alu_op = 4'd6;  6'h2B: b.alu_op = 4'd9;
        default: ill = 1;
      endcase
    end else if (op == 6'h23) begin
      b.alu_src = 1; b.gp_we = 1; b.m2r = 1; b.gpm = 2'b01; b.cad = b.rt;
    end else if (op == 6'h2B) begin
      b.alu_src = 1; b.mem_we = 1;
    end else if (op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) begin
      b.alu_src = 1; b.gp_we = 1; b.cad = b.rt;
      case (op)
        6'h08: begin b.alu_op = 4'd0; b.af = 2'd0; end
        6'h09: begin b.alu_op = 4'd7; b.af = 2'd0; end
        6'h0C: begin b.alu_op = 4'd2; b.af = 2'd1; end
        6'h0D: begin b.alu_op = 4'd3; b.af = 2'd1; end
        6'h0E: begin b.alu_op = 4'd4; b.af = 2'd1; end
        default: begin b.alu_op = 4'd3; b.af = 2'd2; end
      endcase
    end else if (op == 6'h01) begin
      b.pcm = 2'b10; b.bf = (b.rt == 0) ? 3'b010 : 3'b011;
    end else if (op >= 6'h04 && op <= 6'h07) begin
      b.pcm = 2'b10; b.bf = 3'b100 + 3'(op - 6'h04);
    end else if (op == 6'h02) begin
      b.pcm = 2'b11;
    end else if (op == 6'h03) begin
      b.pcm = 2'b11; b.gp_we = 1; b.gpm = 2'b11; b.cad = 5'd31;
    end else ill = 1;
    if (ill) begin b.gp_we = 0; b.mem_we = 0; b.pcm = 2'b00; b.ill = 1; end
    return b;
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [5:0] op, fn;
    bit rs_used, rt_used;
    op = ins[31:26];
    fn = ins[5:0];
    rs_used = !(op == 6'h02 || op == 6'h03 || op == 6'h0F ||
                (op == 6'h00 && fn inside {6'h00, 6'h02, 6'h03}));
    rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
    return (rs_used && ins[25:21] == r) || (rt_used && ins[20:16] == r);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] rfn [18];
    logic [5:0] iop [6];
    logic [4:0] rs, rt, rd;
    int k;
    rfn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20,
            6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    iop = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 11);
    case (k)
      0, 11: return {6'h00, rs, rt, rd, 5'($urandom), rfn[$urandom_range(0, 17)]};
      1:     return {6'h00, rs, rt, rd, 5'($urandom), 6'($urandom)};
      2, 9, 10: return {6'h23, rs, rt, 16'($urandom)};
      3:     return {6'h2B, rs, rt, 16'($urandom)};
      4:     return {iop[$urandom_range(0, 5)], rs, rt, 16'($urandom)};
      5:     return {6'($urandom_range(4, 7)), rs, rt, 16'($urandom)};
      6:     return {6'h01, rs, 5'($urandom_range(0, 1)), 16'($urandom)};
      7:     return {6'($urandom_range(2, 3)), 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  // One cycle of stimulus; entered and left just after a rising edge
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pcv,
                      input bit fl, input bit ordy);
    bit hz, er, acc;
    bundle_t nb;
    in_valid = v; in_instr = ins; in_pc = pcv; flush = fl; out_ready = ordy;
    #1;
    hz = (exp_q.size() > 0) && exp_q[0].m2r && (exp_q[0].cad != 0) && v &&
         reads_reg(ins, exp_q[0].cad);
    er = rst_n && (exp_q.size() == 0 || ordy) && !hz && !fl;
    chk("in_ready", 128'(in_ready), 128'(er));
    acc = v && er;
    nb = model(ins, pcv);
    @(posedge clk);
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back(nb);
    #1;
  endtask

  // Monitor: compares presented bundle with scoreboard head, retires on transfer
  always @(negedge clk) begin
    if (!done) begin
      bundle_t act;
      chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        act = '{out_pc, out_rs, out_rt, out_rd, out_sa, out_imm, out_jidx,
                out_pc_mux_sel, out_gp_mux_sel, out_alu_src, out_gp_we, out_mem_we,
                out_mem_to_reg, out_alu_op, out_af, out_bf, out_cad, out_illegal};
        chk("bundle", 128'(act), 128'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_ADD2 = 32'h00421820;
  localparam logic [31:0] I_LW0  = 32'h8C200000;
  localparam logic [31:0] I_ADD0 = 32'h00001820;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  initial begin
    rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_bundle", 128'({out_pc, out_cad, out_gp_we, out_alu_op}), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // ADD decodes with one-cycle latency
    step(1, I_ADD, 32'h100, 0, 1);
    chk("add_fields", 128'({out_valid, out_alu_op, out_gp_we, out_cad, out_illegal}),
        128'({1'b1, 4'b0000, 1'b1, 5'd3, 1'b0}));
    step(0, 0, 0, 0, 1);

    // Load-use: one refused cycle, one bubble
    step(1, I_LW, 32'h200, 0, 1);
    step(1, I_ADD2, 32'h204, 0, 1);
    chk("bubble", 128'(out_valid), 128'(0));
    step(1, I_ADD2, 32'h204, 0, 1);
    step(0, 0, 0, 0, 1);

    // Load into r0 never stalls
    step(1, I_LW0, 32'h300, 0, 1);
    step(1, I_ADD0, 32'h304, 0, 1);
    chk("r0_b2b", 128'({out_valid, out_pc}), 128'({1'b1, 32'h304}));
    step(0, 0, 0, 0, 1);

    // JAL held under back-pressure
    step(1, I_JAL, 32'h400, 0, 1);
    repeat (3) step(1, I_ADD, 32'h404, 0, 0);
    chk("jal_hold", 128'({out_valid, out_cad, out_gp_mux_sel, out_pc_mux_sel, out_pc}),
        128'({1'b1, 5'd31, 2'b11, 2'b11, 32'h400}));
    step(1, I_ADD, 32'h404, 0, 1);
    step(0, 0, 0, 0, 1);

    // Illegal opcode, then flushed while presented
    step(1, I_ILL, 32'h500, 0, 1);
    chk("illegal", 128'({out_illegal, out_gp_we, out_mem_we, out_pc_mux_sel}),
        128'({1'b1, 1'b0, 1'b0, 2'b00}));
    step(1, I_ADD, 32'h504, 1, 0);
    chk("flush_empty", 128'(out_valid), 128'(0));
    step(0, 0, 0, 0, 1);

    // Asynchronous reset while a bundle is pending
    step(1, I_ADD, 32'h600, 0, 0);
    #2;
    in_valid = 0;
    exp_q.delete();
    rst_n = 0;
    #1;
    chk("async_rst_valid", 128'(out_valid), 128'(0));
    chk("async_rst_ready", 128'(in_ready), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    step(1, I_ADD, 32'h700, 0, 1);
    step(0, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 8, rand_instr(), 32'($urandom) & 32'hFFFF_FFFC,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (3) step(0, 0, 0, 0, 1);

    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
